// File: rtl/find_segment_sched.sv
// find_segment_sched: time-shares one find_segment among NREQ requesters.
// Frames latched on bx_start, issued lowest-id first, results tagged by id.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bx_start          frame start; latches req_v/req_ph/req_q
//   req_v/ph/q        per-requester valid, pattern phi, pattern quality
//   fs_ph_pat/ph_q    issue bus to find_segment (ph_q=0 when idle)
//   fs_vid/hid/cid/sid  match results from find_segment
//   res_*             tagged, registered results (res_v 1-cycle)
//   done/overrun      frame complete / frame aborted pulses
//   drop_cnt          saturating count of dropped requests
module find_segment_sched #(
    parameter int NREQ      = 4,
    parameter int BW_PAT    = 7,
    parameter int SEG_CH    = 2,
    parameter int MATCH_LAT = 1,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bx_start,
    input  logic [NREQ-1:0]        req_v,
    input  logic [NREQ*BW_PAT-1:0] req_ph,
    input  logic [NREQ*6-1:0]      req_q,
    output logic [BW_PAT-1:0]      fs_ph_pat,
    output logic [5:0]             fs_ph_q,
    input  logic [SEG_CH-1:0]      fs_vid,
    input  logic [1:0]             fs_hid,
    input  logic [2:0]             fs_cid,
    input  logic                   fs_sid,
    output logic                   res_v,
    output logic [IDW-1:0]         res_id,
    output logic [SEG_CH-1:0]      res_vid,
    output logic [1:0]             res_hid,
    output logic [2:0]             res_cid,
    output logic                   res_sid,
    output logic                   done,
    output logic                   overrun,
    output logic [7:0]             drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    // All tag stages except the oldest; the oldest pops on this edge.
    localparam logic [MATCH_LAT:0] YMASK =
        {(MATCH_LAT + 1){1'b1}} >> 1;

    state_t state, state_d;

    logic [NREQ-1:0]        pend;
    logic [NREQ*BW_PAT-1:0] ph_lat;
    logic [NREQ*6-1:0]      q_lat;
    logic [MATCH_LAT:0]     tv;
    logic [IDW-1:0]         tid [MATCH_LAT+1];
    logic                   zdone;

    logic [IDW-1:0]  grant;
    logic            found;
    logic [NREQ-1:0] pend_left;
    logic [3:0]      ndrop;
    logic [8:0]      drop_sum;
    logic            grant_en;
    logic            young_busy;
    logic            done_d;
    logic            overrun_d;

    always_comb begin
        grant = '0;
        found = 1'b0;
        ndrop = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && !found) begin
                grant = IDW'(i);
                found = 1'b1;
            end
            ndrop = ndrop + 4'(pend[i]);
        end
    end

    assign pend_left  = pend & ~(NREQ'(1) << grant);
    assign drop_sum   = {1'b0, drop_cnt} + 9'(ndrop);
    assign young_busy = |(tv & YMASK);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        grant_en = 1'b0;
        if (bx_start) begin
            state_d = (|req_v) ? S_ISSUE : S_IDLE;
        end else begin
            unique case (state)
                S_ISSUE: begin
                    grant_en = 1'b1;
                    if (pend_left == '0) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (!young_busy) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
        // Final drain edge signals done even if a new frame starts.
        done_d    = zdone | (state == S_DRAIN && !young_busy);
        overrun_d = bx_start && state == S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            ph_lat    <= '0;
            q_lat     <= '0;
            zdone     <= 1'b0;
            fs_ph_pat <= '0;
            fs_ph_q   <= '0;
            tv        <= '0;
            for (int i = 0; i <= MATCH_LAT; i++) tid[i] <= '0;
            res_v     <= 1'b0;
            res_id    <= '0;
            res_vid   <= '0;
            res_hid   <= '0;
            res_cid   <= '0;
            res_sid   <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            zdone   <= bx_start && !(|req_v);
            done    <= done_d;
            overrun <= overrun_d;
            if (bx_start) begin
                pend   <= req_v;
                ph_lat <= req_ph;
                q_lat  <= req_q;
            end else if (grant_en) begin
                pend <= pend_left;
            end
            if (overrun_d) begin
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
            if (grant_en) begin
                fs_ph_pat <= ph_lat[grant*BW_PAT +: BW_PAT];
                fs_ph_q   <= q_lat[grant*6 +: 6];
            end else begin
                fs_ph_q   <= '0;
            end
            tv[0]  <= grant_en;
            tid[0] <= grant;
            for (int i = 1; i <= MATCH_LAT; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
            end
            res_v <= tv[MATCH_LAT];
            if (tv[MATCH_LAT]) begin
                res_id  <= tid[MATCH_LAT];
                res_vid <= fs_vid;
                res_hid <= fs_hid;
                res_cid <= fs_cid;
                res_sid <= fs_sid;
            end
        end
    end

endmodule

// File: tb/tb_find_segment_sched.sv
// tb_find_segment_sched: random and directed frames against a frame-level
// reference model; a monitor scoreboards tagged results as they appear.
module tb_find_segment_sched;

    localparam int NREQ = 4;
    localparam int BW   = 7;
    localparam int SC   = 2;
    localparam int ML   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             bx_start;
    logic [NREQ-1:0]  req_v;
    logic [NREQ*BW-1:0] req_ph;
    logic [NREQ*6-1:0]  req_q;
    logic [BW-1:0]    fs_ph_pat;
    logic [5:0]       fs_ph_q;
    logic [SC-1:0]    fs_vid;
    logic [1:0]       fs_hid;
    logic [2:0]       fs_cid;
    logic             fs_sid;
    logic             res_v;
    logic [1:0]       res_id;
    logic [SC-1:0]    res_vid;
    logic [1:0]       res_hid;
    logic [2:0]       res_cid;
    logic             res_sid;
    logic             done;
    logic             overrun;
    logic [7:0]       drop_cnt;

    find_segment_sched #(
        .NREQ(NREQ), .BW_PAT(BW), .SEG_CH(SC), .MATCH_LAT(ML)
    ) dut (
        .clk(clk), .rst(rst), .bx_start(bx_start),
        .req_v(req_v), .req_ph(req_ph), .req_q(req_q),
        .fs_ph_pat(fs_ph_pat), .fs_ph_q(fs_ph_q),
        .fs_vid(fs_vid), .fs_hid(fs_hid),
        .fs_cid(fs_cid), .fs_sid(fs_sid),
        .res_v(res_v), .res_id(res_id),
        .res_vid(res_vid), .res_hid(res_hid),
        .res_cid(res_cid), .res_sid(res_sid),
        .done(done), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] f;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   ov_seen = 0;
    int   exp_done = 0;
    int   exp_ov = 0;
    int   drop_model = 0;

    // Stand-in find_segment: {vid, hid, cid, sid}, no match when q == 0.
    function automatic logic [7:0] fsf(logic [6:0] ph, logic [5:0] q);
        logic [1:0] v;
        v = (q == 6'd0) ? 2'b00 : (ph[1:0] ^ q[1:0]);
        return {v, ph[3:2], ph[6:4], q[5]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        {fs_vid, fs_hid, fs_cid, fs_sid} <= fsf(fs_ph_pat, fs_ph_q);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (res_v) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_res id=%0d cyc=%0d",
                             res_id, cyc);
                end else begin
                    me = exp_q.pop_front();
                    if (int'(res_id) != me.id ||
                        {res_vid, res_hid, res_cid, res_sid} !== me.f ||
                        cyc != me.cyc) begin
                        fails++;
                        $display("FAIL res got id=%0d f=%h cyc=%0d want id=%0d f=%h cyc=%0d",
                                 res_id,
                                 {res_vid, res_hid, res_cid, res_sid},
                                 cyc, me.id, me.f, me.cyc);
                    end
                end
            end
            if (done)    done_seen++;
            if (overrun) ov_seen++;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Starts a frame now; gap = edges until the next frame start,
    // or 0 to let the frame run to completion.
    task automatic run_frame(input logic [3:0] v, input logic [27:0] ph,
                             input logic [23:0] q, input int gap);
        int n, issued, k, e0;
        exp_t e;
        n = $countones(v);
        if (gap == 0) issued = n;
        else          issued = (gap - 1 < n) ? gap - 1 : n;
        req_v = v;
        req_ph = ph;
        req_q = q;
        bx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        bx_start = 1'b0;
        req_v = 4'($urandom);
        req_ph = 28'($urandom);
        req_q = 24'($urandom);
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && k < issued) begin
                k++;
                e.id = i;
                e.f = fsf(ph[i*BW +: BW], q[i*6 +: 6]);
                e.cyc = e0 + k + ML + 1;
                exp_q.push_back(e);
            end
        end
        if (issued < n) begin
            exp_ov++;
            drop_model = drop_model + n - issued;
            if (drop_model > 255) drop_model = 255;
        end
        if (n == 0 || gap == 0 || gap >= n + 2) exp_done++;
        if (gap == 0) repeat (n + 4) @(negedge clk);
        else          repeat (gap - 1) @(negedge clk);
    endtask

    task automatic checkpoint(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done"}, 64'(done_seen), 64'(exp_done));
        check({name, "_overrun"}, 64'(ov_seen), 64'(exp_ov));
        check({name, "_drop"}, 64'(drop_cnt), 64'(drop_model));
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({res_v, res_id, res_vid, res_hid, res_cid,
                         res_sid, done, overrun, drop_cnt,
                         fs_ph_pat, fs_ph_q}), 64'd0);
    endtask

    function automatic logic [23:0] rand_q();
        logic [23:0] q;
        for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(3) == 0) q[i*6 +: 6] = 6'd0;
            else q[i*6 +: 6] = 6'($urandom_range(63, 1));
        end
        return q;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bx_start = 1'b0;
        req_v = '0;
        req_ph = '0;
        req_q = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_outs");
        rst = 1'b0;
        @(negedge clk);

        run_frame(4'b1011, 28'h5A3C1E7, 24'h8A5C31, 0);
        checkpoint("c1");

        run_frame(4'b0000, 28'h1234567, 24'h654321, 0);
        check("c2_fs_q", 64'(fs_ph_q), 64'd0);
        checkpoint("c2");

        run_frame(4'b1111, 28'hABCDEF1, 24'h7E5D3C, 2);
        run_frame(4'b0110, 28'h0F0F0F0, 24'h00FFC3, 0);
        checkpoint("c3");

        run_frame(4'b0100, {7'd0, 7'b1011000, 14'd0},
                  {6'd0, 6'b100010, 12'd0}, 0);
        checkpoint("c4");

        run_frame(4'b0011, 28'h3141592, 24'h271828, 3);
        run_frame(4'b0101, 28'h1618033, 24'h141421, 4);
        run_frame(4'b1001, 28'h7777777, 24'h0C0C0C, 0);
        checkpoint("drain_edges");

        for (int i = 0; i < 40; i++) begin
            run_frame(4'($urandom), 28'($urandom), rand_q(),
                      $urandom_range(7));
        end
        run_frame(4'($urandom), 28'($urandom), rand_q(), 0);
        checkpoint("random");

        req_v = 4'b1011;
        req_ph = 28'($urandom);
        req_q = 24'hFFFFFF;
        bx_start = 1'b1;
        @(negedge clk);
        bx_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("c5_reset_outs");
        rst = 1'b0;
        exp_q.delete();
        drop_model = 0;
        repeat (8) @(negedge clk);
        checkpoint("c5");

        for (int i = 0; i < 90; i++) begin
            run_frame(4'b1111, 28'($urandom), rand_q(), 2);
        end
        run_frame(4'b1111, 28'($urandom), rand_q(), 0);
        checkpoint("c6");
        check("c6_sat", 64'(drop_cnt), 64'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
